// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed four-digit seven-segment display.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;
    localparam seg_t SEG_DASH  = 8'hBF;
    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seven_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seven_seg_mux.sv
// Time-multiplexed four-digit BCD display driver with prescaled digit scan.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_seven_seg_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [15:0] bcd_i,
    output logic [3:0]  an_o,
    output logic [7:0]  seg_o,
    output logic        err_o
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic             err_q, err_d;
    logic             terminal;
    logic [3:0]       cur_nib;
    seg_t             dec_seg;
    logic             blank;

    function automatic logic has_invalid(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[k*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        terminal = (pre_q == PRE_W'(REFRESH_DIV - 1));
        pre_d    = terminal ? '0 : pre_q + PRE_W'(1);
        idx_d    = terminal ? idx_q + 2'd1 : idx_q;
        disp_d   = disp_q;
        err_d    = err_q;
        if (load_i) begin
            disp_d = bcd_i;
            err_d  = has_invalid(bcd_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pre_q  <= '0;
            idx_q  <= 2'd0;
            disp_q <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            err_q  <= err_d;
        end
    end

    assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

    bcd_to_seven_seg u_dec (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is blank only when it and every more-significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd1:    blank = (disp_q[15:4]  == 12'h000);
            2'd2:    blank = (disp_q[15:8]  == 8'h00);
            2'd3:    blank = (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_o = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == 2'(k)) an_o[k] = 1'b0;
        end
    end

    assign seg_o = blank ? SEG_BLANK : dec_seg;
    assign err_o = err_q;

endmodule
